ctrl_code_encode: RTL and testbench
===================================

# ctrl_code_encode

Generates the IFM control link: a periodic FPRI pulse plus an MSB-first serial `code` frame that carries the full control word set. The frame holds check bytes AA/55, mode/code bytes, PRI code and the four phase words. The block acts as a bench or loop-back source for the decode path and as the IFM-side transmitter on test boards. It runs in the 100 MHz system domain and drives the `FPRI`/`code` pins directly.

## Interface
Parameters:
- `BIT_DIV`, 4 — clocks per serial bit (25 Mbit/s at 100 MHz); minimum 2.
- `FPRI_W`, 8 — FPRI high time in clocks; 1..`BIT_DIV`*160.
- `DEF_PRT`, 30000 — period used when `prt_len` is 0.

Ports:
- `clk_100M` in 1 — system clock.
- `rst` in 1 — synchronous, active-high reset.
- `en` in 1 — run request.
- `prt_len` in 16 — period length in clocks.
- `work_mode`, `ver_code`, `hor_code`, `wave_code`, `fre_code`, `pulse_mode`, `monitor_addr`, `monitor_mode` in 8 each — frame fields.
- `pri_code`, `hor_phase_R`, `ver_phase_R`, `hor_phase_T`, `ver_phase_T` in 16 each — frame fields.
- `FPRI` out 1 — period start pulse.
- `code` out 1 — serial frame.
- `busy` out 1 — high while not in IDLE.
- `frame_done` out 1 — one-cycle pulse after the last bit.
- `frame_cnt` out 16 — frames sent, wraps at 0xFFFF→0.

## Operation
- Frame is 20 bytes (160 bits), sent MSB first. Byte order:
  - AA, 55, work_mode, ver_code, hor_code, wave_code, fre_code
  - pri_code[15:8], pri_code[7:0], pulse_mode, monitor_addr, monitor_mode
  - hor_phase_R hi/lo, ver_phase_R hi/lo, hor_phase_T hi/lo, ver_phase_T hi/lo.
- FSM states:
  - IDLE: `busy`=0, `FPRI`=0, `code`=0. On `en`=1 → SEND.
  - SEND: period counter `pc` runs from 0. `code` = frame bit `pc/BIT_DIV`. After bit 159 completes → GAP.
  - GAP: `code`=0. At `pc`=`P`-1: if `en`=1 → SEND with a new period; otherwise → IDLE.
- Snapshot: all field inputs and `prt_len` are registered into a 160-bit shift register and a period register on every entry to SEND. Input changes mid-period do not affect the current frame.
- Effective period `P`:
  - `DEF_PRT` if `prt_len`=0.
  - Otherwise max(`prt_len`, MIN_PRT), where MIN_PRT = 160·`BIT_DIV`+2.
  - `pc` is 16 bits and wraps to 0 only at `P`-1.
- `FPRI` = 1 while `pc` < `FPRI_W` in SEND.
- `en` deasserted mid-period: the current period completes in full, then the block goes to IDLE. No truncated frames.
- `frame_done` and the `frame_cnt` increment occur in the same cycle.

## Timing
- Reset values: `FPRI`=0, `code`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, state IDLE, `pc`=0.
- `rst` mid-frame: all outputs take their reset values on the next edge. No partial frame resumes.
- Start latency: `en` sampled high in IDLE at edge N → `FPRI`=1, `busy`=1, `code`=bit159 (1) at N+1.
- Bit k of the frame (k=0 is the first bit) is held on `code` for clocks [k·`BIT_DIV`, (k+1)·`BIT_DIV`) after the FPRI rise.
- `frame_done` is high at `pc` = 160·`BIT_DIV` (GAP entry) for one cycle.
- Back-to-back periods: the FPRI rising edges are exactly `P` clocks apart. No idle cycle is inserted between periods.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Package `ctrl_code_pkg` holds:
  - `CHK1`=8'hAA, `CHK2`=8'h55.
  - `FRAME_BYTES`=20, `FRAME_BITS`=160.
  - Byte-offset constants per field.
  - The FSM state enum.
- Sub-module `ctrl_frame_pack` is purely combinational: fields → 160-bit frame vector in package byte order. The top module holds the FSM, counters and shift register.

## Test plan
- Reset then `en`=1 with `prt_len`=1000, `work_mode`=8'h3C, `pri_code`=16'h1234 → first 16 bits on `code` are 1010_1010_0101_0101. FPRI rises are 1000 clocks apart. `frame_done` occurs at `pc`=640.
- `prt_len`=100 (below MIN_PRT=642) → period clamps to 642. `prt_len`=0 → period 30000.
- Change `hor_phase_T` from 16'h0F0F to 16'hF0F0 mid-frame → the current frame still carries 0F0F. The next frame carries F0F0.
- Drop `en` at `pc`=200 → the frame completes, the period ends at `P`-1, and `busy`=0 on the next cycle. No second FPRI.
- Assert `rst` at `pc`=300 → `FPRI`/`code`/`busy`=0 on the next edge and `frame_cnt`=0. Restart then produces a full frame.
- Loop-back into the decode path for 4 frames with random fields → all decoded fields match. `frame_cnt`=4.

Source files
------------

// File: rtl/ctrl_code_encode_pkg.sv
// ctrl_code_pkg: shared constants and types for the IFM control-link encoder.
//   - CHK1/CHK2: frame check bytes
//   - FRAME_BYTES/FRAME_BITS: frame geometry
//   - OFS_*: byte position of each field in transmission order (0 = first byte)
//   - state_e: encoder FSM states
//   - ctrl_fields_t: the control word set carried by one frame
package ctrl_code_pkg;

    localparam logic [7:0] CHK1 = 8'hAA;
    localparam logic [7:0] CHK2 = 8'h55;

    localparam int FRAME_BYTES = 20;
    localparam int FRAME_BITS  = 160;

    // Byte offsets in transmission order; 5 bits wide to index a 20-byte array directly
    localparam logic [4:0] OFS_CHK1       = 5'd0;
    localparam logic [4:0] OFS_CHK2       = 5'd1;
    localparam logic [4:0] OFS_WORK_MODE  = 5'd2;
    localparam logic [4:0] OFS_VER_CODE   = 5'd3;
    localparam logic [4:0] OFS_HOR_CODE   = 5'd4;
    localparam logic [4:0] OFS_WAVE_CODE  = 5'd5;
    localparam logic [4:0] OFS_FRE_CODE   = 5'd6;
    localparam logic [4:0] OFS_PRI_HI     = 5'd7;
    localparam logic [4:0] OFS_PRI_LO     = 5'd8;
    localparam logic [4:0] OFS_PULSE_MODE = 5'd9;
    localparam logic [4:0] OFS_MON_ADDR   = 5'd10;
    localparam logic [4:0] OFS_MON_MODE   = 5'd11;
    localparam logic [4:0] OFS_HPR_HI     = 5'd12;
    localparam logic [4:0] OFS_HPR_LO     = 5'd13;
    localparam logic [4:0] OFS_VPR_HI     = 5'd14;
    localparam logic [4:0] OFS_VPR_LO     = 5'd15;
    localparam logic [4:0] OFS_HPT_HI     = 5'd16;
    localparam logic [4:0] OFS_HPT_LO     = 5'd17;
    localparam logic [4:0] OFS_VPT_HI     = 5'd18;
    localparam logic [4:0] OFS_VPT_LO     = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  work_mode;
        logic [7:0]  ver_code;
        logic [7:0]  hor_code;
        logic [7:0]  wave_code;
        logic [7:0]  fre_code;
        logic [15:0] pri_code;
        logic [7:0]  pulse_mode;
        logic [7:0]  monitor_addr;
        logic [7:0]  monitor_mode;
        logic [15:0] hor_phase_R;
        logic [15:0] ver_phase_R;
        logic [15:0] hor_phase_T;
        logic [15:0] ver_phase_T;
    } ctrl_fields_t;

endpackage

// File: rtl/ctrl_code_encode_if.sv
// ctrl_code_encode_if: control-link bundle between a field source and the encoder.
//   master: drives run request, period length and frame fields; observes link pins/status.
//   slave : the encoder; consumes fields, drives FPRI, code, busy, frame_done, frame_cnt.
interface ctrl_code_encode_if;

    logic        en;
    logic [15:0] prt_len;
    logic [7:0]  work_mode;
    logic [7:0]  ver_code;
    logic [7:0]  hor_code;
    logic [7:0]  wave_code;
    logic [7:0]  fre_code;
    logic [7:0]  pulse_mode;
    logic [7:0]  monitor_addr;
    logic [7:0]  monitor_mode;
    logic [15:0] pri_code;
    logic [15:0] hor_phase_R;
    logic [15:0] ver_phase_R;
    logic [15:0] hor_phase_T;
    logic [15:0] ver_phase_T;

    logic        FPRI;
    logic        code;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (
        output en, prt_len, work_mode, ver_code, hor_code, wave_code, fre_code,
               pulse_mode, monitor_addr, monitor_mode, pri_code,
               hor_phase_R, ver_phase_R, hor_phase_T, ver_phase_T,
        input  FPRI, code, busy, frame_done, frame_cnt
    );

    modport slave (
        input  en, prt_len, work_mode, ver_code, hor_code, wave_code, fre_code,
               pulse_mode, monitor_addr, monitor_mode, pri_code,
               hor_phase_R, ver_phase_R, hor_phase_T, ver_phase_T,
        output FPRI, code, busy, frame_done, frame_cnt
    );

endinterface

// File: rtl/ctrl_code_encode_frame_pack.sv
// ctrl_frame_pack: combinational packer, control fields -> 160-bit frame vector.
//   fields : control word set
//   frame  : frame[159] is the first bit on the wire (byte 0, MSB)
module ctrl_frame_pack
    import ctrl_code_pkg::*;
(
    input  ctrl_fields_t            fields,
    output logic [FRAME_BITS-1:0]   frame
);

    // Ascending byte index so bytes[0] lands in the MSB byte of the vector
    logic [0:FRAME_BYTES-1][7:0] bytes;

    always_comb begin
        bytes                 = '0;
        bytes[OFS_CHK1]       = CHK1;
        bytes[OFS_CHK2]       = CHK2;
        bytes[OFS_WORK_MODE]  = fields.work_mode;
        bytes[OFS_VER_CODE]   = fields.ver_code;
        bytes[OFS_HOR_CODE]   = fields.hor_code;
        bytes[OFS_WAVE_CODE]  = fields.wave_code;
        bytes[OFS_FRE_CODE]   = fields.fre_code;
        bytes[OFS_PRI_HI]     = fields.pri_code[15:8];
        bytes[OFS_PRI_LO]     = fields.pri_code[7:0];
        bytes[OFS_PULSE_MODE] = fields.pulse_mode;
        bytes[OFS_MON_ADDR]   = fields.monitor_addr;
        bytes[OFS_MON_MODE]   = fields.monitor_mode;
        bytes[OFS_HPR_HI]     = fields.hor_phase_R[15:8];
        bytes[OFS_HPR_LO]     = fields.hor_phase_R[7:0];
        bytes[OFS_VPR_HI]     = fields.ver_phase_R[15:8];
        bytes[OFS_VPR_LO]     = fields.ver_phase_R[7:0];
        bytes[OFS_HPT_HI]     = fields.hor_phase_T[15:8];
        bytes[OFS_HPT_LO]     = fields.hor_phase_T[7:0];
        bytes[OFS_VPT_HI]     = fields.ver_phase_T[15:8];
        bytes[OFS_VPT_LO]     = fields.ver_phase_T[7:0];
    end

    assign frame = bytes;

endmodule

// File: rtl/ctrl_code_encode.sv
// ctrl_code_encode: IFM control-link transmitter.
//   clk_100M : system clock
//   rst      : synchronous active-high reset
//   bus      : slave side of ctrl_code_encode_if
//              in : en, prt_len, frame fields
//              out: FPRI (period start pulse), code (MSB-first serial frame),
//                   busy, frame_done (1-cycle), frame_cnt (wrapping)
// Each period: FPRI high for FPRI_W clocks, 160 bits at BIT_DIV clocks/bit,
// then a gap until the period counter reaches P-1.
module ctrl_code_encode
    import ctrl_code_pkg::*;
#(
    parameter int BIT_DIV = 4,
    parameter int FPRI_W  = 8,
    parameter int DEF_PRT = 30000
)
(
    input  logic               clk_100M,
    input  logic               rst,
    ctrl_code_encode_if.slave  bus
);

    localparam int              DIV_W     = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [15:0]     SEND_LAST = 16'(FRAME_BITS * BIT_DIV - 1);
    // Two gap cycles minimum so frame_done always lands inside the period
    localparam logic [15:0]     MIN_PRT   = 16'(FRAME_BITS * BIT_DIV + 2);
    localparam logic [15:0]     DEF_P     = 16'(DEF_PRT);
    localparam logic [15:0]     FPRI_LEN  = 16'(FPRI_W);

    state_e                  state_q, state_d;
    logic [15:0]             pc_q, pc_d;
    logic [15:0]             per_q, per_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    fpri_q, fpri_d;
    logic                    code_q, code_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    start;
    logic [15:0]             per_new;
    ctrl_fields_t            fields_in;
    logic [FRAME_BITS-1:0]   frame;

    assign fields_in = '{
        work_mode:    bus.work_mode,
        ver_code:     bus.ver_code,
        hor_code:     bus.hor_code,
        wave_code:    bus.wave_code,
        fre_code:     bus.fre_code,
        pri_code:     bus.pri_code,
        pulse_mode:   bus.pulse_mode,
        monitor_addr: bus.monitor_addr,
        monitor_mode: bus.monitor_mode,
        hor_phase_R:  bus.hor_phase_R,
        ver_phase_R:  bus.ver_phase_R,
        hor_phase_T:  bus.hor_phase_T,
        ver_phase_T:  bus.ver_phase_T
    };

    ctrl_frame_pack u_pack (
        .fields (fields_in),
        .frame  (frame)
    );

    always_comb begin
        if (bus.prt_len == 16'd0)        per_new = DEF_P;
        else if (bus.prt_len < MIN_PRT)  per_new = MIN_PRT;
        else                             per_new = bus.prt_len;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        per_d   = per_q;
        div_d   = div_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        start   = 1'b0;

        unique case (state_q)
            ST_IDLE: start = bus.en;
            ST_SEND: begin
                pc_d = pc_q + 16'd1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
                end else begin
                    div_d = div_q + 1'b1;
                end
                if (pc_q == SEND_LAST) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (pc_q == per_q - 16'd1) begin
                    if (bus.en) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        pc_d    = '0;
                    end
                end else begin
                    pc_d = pc_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase

        // New period: snapshot fields and period so mid-period input changes are ignored
        if (start) begin
            state_d = ST_SEND;
            pc_d    = '0;
            div_d   = '0;
            sr_d    = frame;
            per_d   = per_new;
        end

        // Outputs are computed from next state so they register alongside it
        fpri_d = (state_d == ST_SEND) && (pc_d < FPRI_LEN);
        code_d = (state_d == ST_SEND) && sr_d[FRAME_BITS-1];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            per_q   <= '0;
            div_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            fpri_q  <= 1'b0;
            code_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            per_q   <= per_d;
            div_q   <= div_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            fpri_q  <= fpri_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.FPRI       = fpri_q;
    assign bus.code       = code_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_code_encode.sv
// Self-checking bench for ctrl_code_encode: a period-level reference model is
// compared against the DUT every cycle, and a receiver monitor decodes the serial
// frames for directed and random scenario checks.
module tb_ctrl_code_encode;

    localparam int BD   = 4;
    localparam int FW   = 8;
    localparam int DP   = 30000;
    localparam int SEND = 160 * BD;
    localparam int MINP = SEND + 2;

    typedef struct {
        logic [7:0]  wm, vc, hc, wc, fc;
        logic [15:0] pri;
        logic [7:0]  pm, ma, mm;
        logic [15:0] hpr, vpr, hpt, vpt;
    } fld_t;

    logic clk_100M = 1'b0;
    logic rst = 1'b1;
    ctrl_code_encode_if bus();

    ctrl_code_encode #(.BIT_DIV(BD), .FPRI_W(FW), .DEF_PRT(DP)) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_100M = ~clk_100M;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    int cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame layout straight from the byte-order table
    function automatic logic [7:0] fbyte(fld_t f, int i);
        case (i)
            0: return 8'hAA;          1: return 8'h55;
            2: return f.wm;           3: return f.vc;
            4: return f.hc;           5: return f.wc;
            6: return f.fc;           7: return f.pri[15:8];
            8: return f.pri[7:0];     9: return f.pm;
            10: return f.ma;          11: return f.mm;
            12: return f.hpr[15:8];   13: return f.hpr[7:0];
            14: return f.vpr[15:8];   15: return f.vpr[7:0];
            16: return f.hpt[15:8];   17: return f.hpt[7:0];
            18: return f.vpt[15:8];   19: return f.vpt[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic bitof(fld_t f, int k);
        logic [7:0] b;
        b = fbyte(f, k / 8);
        return b[7 - (k % 8)];
    endfunction

    function automatic logic [7:0] frame_byte(logic [159:0] fr, int i);
        return fr[159 - 8*i -: 8];
    endfunction

    function automatic int eff_period(int pl);
        if (pl == 0) return DP;
        return (pl < MINP) ? MINP : pl;
    endfunction

    function automatic fld_t bus_fields();
        fld_t f;
        f.wm = bus.work_mode;   f.vc = bus.ver_code;     f.hc = bus.hor_code;
        f.wc = bus.wave_code;   f.fc = bus.fre_code;     f.pri = bus.pri_code;
        f.pm = bus.pulse_mode;  f.ma = bus.monitor_addr; f.mm = bus.monitor_mode;
        f.hpr = bus.hor_phase_R; f.vpr = bus.ver_phase_R;
        f.hpt = bus.hor_phase_T; f.vpt = bus.ver_phase_T;
        return f;
    endfunction

    function automatic fld_t rand_fields();
        fld_t f;
        f.wm = 8'($urandom);  f.vc = 8'($urandom);  f.hc = 8'($urandom);
        f.wc = 8'($urandom);  f.fc = 8'($urandom);  f.pri = 16'($urandom);
        f.pm = 8'($urandom);  f.ma = 8'($urandom);  f.mm = 8'($urandom);
        f.hpr = 16'($urandom); f.vpr = 16'($urandom);
        f.hpt = 16'($urandom); f.vpt = 16'($urandom);
        return f;
    endfunction

    task automatic drive_fields(fld_t f);
        bus.work_mode = f.wm;   bus.ver_code = f.vc;     bus.hor_code = f.hc;
        bus.wave_code = f.wc;   bus.fre_code = f.fc;     bus.pri_code = f.pri;
        bus.pulse_mode = f.pm;  bus.monitor_addr = f.ma; bus.monitor_mode = f.mm;
        bus.hor_phase_R = f.hpr; bus.ver_phase_R = f.vpr;
        bus.hor_phase_T = f.hpt; bus.ver_phase_T = f.vpt;
    endtask

    // Reference model: position inside the current period plus the snapshot taken at its start
    bit   m_run = 1'b0;
    int   m_t   = 0;
    int   m_p   = 0;
    int   m_cnt = 0;
    fld_t m_f;

    always @(posedge clk_100M) begin
        cyc++;
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_cnt = 0;
        end else if (!m_run || m_t == m_p - 1) begin
            if (bus.en) begin
                m_run = 1'b1; m_t = 0;
                m_p = eff_period(int'(bus.prt_len));
                m_f = bus_fields();
            end else begin
                m_run = 1'b0; m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == SEND) m_cnt = (m_cnt + 1) % 65536;
        end
    end

    always @(negedge clk_100M) begin
        if (cmp_on) begin
            chk("fpri", bus.FPRI, m_run && m_t < FW);
            chk("code", bus.code, m_run && m_t < SEND && bitof(m_f, m_t / BD));
            chk("busy", bus.busy, m_run);
            chk("frame_done", bus.frame_done, m_run && m_t == SEND);
            chk("frame_cnt", bus.frame_cnt, m_cnt);
        end
    end

    // Receiver: timestamps FPRI rises, samples code at each bit start, logs frame_done offset
    int           rises[$];
    logic [159:0] frames[$];
    int           done_offs[$];
    bit           fpri_prev = 1'b0;
    bit           capturing = 1'b0;
    int           mon_off = 0;
    logic [159:0] cap = '0;

    always @(negedge clk_100M) begin
        if (rst || bus.busy !== 1'b1) capturing = 1'b0;
        if (bus.FPRI === 1'b1 && !fpri_prev) begin
            rises.push_back(cyc);
            capturing = 1'b1; mon_off = 0; cap = '0;
        end else if (capturing) begin
            mon_off++;
        end
        if (capturing) begin
            if (mon_off < SEND && mon_off % BD == 0) begin
                cap = {cap[158:0], bus.code};
                if (mon_off == SEND - BD) frames.push_back(cap);
            end
            if (bus.frame_done === 1'b1) done_offs.push_back(mon_off);
        end
        fpri_prev = (bus.FPRI === 1'b1);
    end

    task automatic step();
        @(negedge clk_100M);
        #1;
    endtask

    task automatic wait_rises(int n, int maxc);
        int k = 0;
        while (rises.size() < n && k < maxc) begin step(); k++; end
        chk("rise_wait", rises.size() >= n, 1'b1);
    endtask

    task automatic wait_frames(int n, int maxc);
        int k = 0;
        while (frames.size() < n && k < maxc) begin step(); k++; end
        chk("frame_wait", frames.size() >= n, 1'b1);
    endtask

    task automatic wait_off(int n);
        int k = 0;
        while (mon_off != n && k < n + 20) begin step(); k++; end
        chk("offset_wait", mon_off, n);
    endtask

    // Drop en and return the cycle on which busy is first seen low
    task automatic stop_idle(output int fall);
        int k = 0;
        bus.en = 1'b0;
        while (bus.busy !== 1'b0 && k < 35000) begin step(); k++; end
        chk("idle_wait", bus.busy, 1'b0);
        fall = cyc;
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fld_t f, f2;
        fld_t lb[4];
        logic [159:0] fr;
        int r0, b0, d0, c0, fall;

        bus.en = 1'b0;
        bus.prt_len = '0;
        f = '{default: '0};
        drive_fields(f);
        rst = 1'b1;
        repeat (3) step();
        cmp_on = 1'b1;
        chk("rst_fpri", bus.FPRI, 1'b0);
        chk("rst_code", bus.code, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.frame_done, 1'b0);
        chk("rst_cnt", bus.frame_cnt, 16'd0);
        rst = 1'b0;
        step();

        // Basic period: 1000 clocks, check bytes, latency, spacing and frame_done offset
        f = rand_fields(); f.wm = 8'h3C; f.pri = 16'h1234;
        drive_fields(f);
        bus.prt_len = 16'd1000;
        r0 = rises.size(); b0 = frames.size(); d0 = done_offs.size();
        c0 = cyc;
        bus.en = 1'b1;
        wait_rises(r0 + 3, 4000);
        chk("start_latency", rises[r0] - c0, 1);
        chk("spacing_1000_a", rises[r0+1] - rises[r0], 1000);
        chk("spacing_1000_b", rises[r0+2] - rises[r0+1], 1000);
        fr = frames[b0];
        chk("first16", fr[159:144], 16'hAA55);
        chk("work_mode_byte", frame_byte(fr, 2), 8'h3C);
        chk("pri_hi_byte", frame_byte(fr, 7), 8'h12);
        chk("pri_lo_byte", frame_byte(fr, 8), 8'h34);
        chk("done_offset", done_offs[d0], 640);
        stop_idle(fall);

        // Clamp: prt_len below minimum
        bus.prt_len = 16'd100;
        r0 = rises.size();
        bus.en = 1'b1;
        wait_rises(r0 + 2, 2000);
        chk("spacing_clamp", rises[r0+1] - rises[r0], 642);
        stop_idle(fall);
        chk("fall_clamp", fall - rises[r0+1], 642);

        // Default period: prt_len = 0, one period only
        bus.prt_len = 16'd0;
        r0 = rises.size();
        bus.en = 1'b1;
        wait_rises(r0 + 1, 50);
        stop_idle(fall);
        chk("fall_default", fall - rises[r0], 30000);
        chk("default_one_rise", rises.size(), r0 + 1);

        // Snapshot: change hor_phase_T mid-frame
        f = rand_fields(); f.hpt = 16'h0F0F;
        drive_fields(f);
        bus.prt_len = 16'd1000;
        r0 = rises.size(); b0 = frames.size();
        bus.en = 1'b1;
        wait_rises(r0 + 1, 50);
        repeat (100) step();
        bus.hor_phase_T = 16'hF0F0;
        wait_rises(r0 + 2, 1200);
        wait_frames(b0 + 2, 1000);
        stop_idle(fall);
        fr = frames[b0];
        chk("snap_old_hi", frame_byte(fr, 16), 8'h0F);
        chk("snap_old_lo", frame_byte(fr, 17), 8'h0F);
        fr = frames[b0+1];
        chk("snap_new_hi", frame_byte(fr, 16), 8'hF0);
        chk("snap_new_lo", frame_byte(fr, 17), 8'hF0);

        // Drop en at pc=200: full frame, full period, then idle with no further FPRI
        drive_fields(rand_fields());
        bus.prt_len = 16'd1000;
        r0 = rises.size(); b0 = frames.size(); d0 = done_offs.size();
        bus.en = 1'b1;
        wait_rises(r0 + 1, 50);
        wait_off(200);
        stop_idle(fall);
        chk("drop_fall", fall - rises[r0], 1000);
        chk("drop_frames", frames.size(), b0 + 1);
        chk("drop_done_off", done_offs[d0], 640);
        repeat (1500) step();
        chk("drop_no_rise", rises.size(), r0 + 1);

        // Reset at pc=300, then a clean restart
        drive_fields(rand_fields());
        bus.prt_len = 16'd800;
        r0 = rises.size();
        bus.en = 1'b1;
        wait_rises(r0 + 1, 50);
        wait_off(300);
        rst = 1'b1;
        bus.en = 1'b0;
        step();
        chk("midrst_fpri", bus.FPRI, 1'b0);
        chk("midrst_code", bus.code, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_cnt", bus.frame_cnt, 16'd0);
        rst = 1'b0;
        step();
        f2 = rand_fields();
        drive_fields(f2);
        r0 = rises.size(); b0 = frames.size(); d0 = done_offs.size();
        bus.en = 1'b1;
        wait_rises(r0 + 1, 50);
        wait_frames(b0 + 1, 700);
        repeat (10) step();
        fr = frames[b0];
        for (int j = 0; j < 20; j++) chk("restart_byte", frame_byte(fr, j), fbyte(f2, j));
        chk("restart_done_off", done_offs[d0], 640);
        chk("restart_cnt", bus.frame_cnt, 16'd1);
        stop_idle(fall);

        // Loop-back: 4 random frames with random periods
        rst = 1'b1; step(); rst = 1'b0; step();
        r0 = rises.size(); b0 = frames.size();
        for (int i = 0; i < 4; i++) begin
            lb[i] = rand_fields();
            drive_fields(lb[i]);
            bus.prt_len = 16'($urandom_range(1, 1100));
            if (i == 0) bus.en = 1'b1;
            wait_rises(r0 + i + 1, 1200);
        end
        stop_idle(fall);
        chk("loop_frames", frames.size(), b0 + 4);
        chk("loop_cnt", bus.frame_cnt, 16'd4);
        for (int i = 0; i < 4; i++) begin
            fr = frames[b0 + i];
            for (int j = 0; j < 20; j++) chk("loop_field", frame_byte(fr, j), fbyte(lb[i], j));
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
